// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding/hazard controller: operand-mux select codes
// and the shadow copy of a pipeline stage's destination-register state.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXALU  = 2'b01,
    FWD_MEMALU = 2'b10,
    FWD_MEMMO  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic             v;
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] rn;
  } stage_slot;

  // True when the slot will write register r; r0 is hardwired and never produced.
  function automatic logic produces(stage_slot s, logic [REG_W-1:0] r);
    return s.v & s.wreg & (s.rn != '0) & (s.rn == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and forwarding/stall response bundle between the pipeline
// (master) and the hazard controller (slave).
interface fwd_hazard_ctrl_if #(
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 16
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wreg;
  logic          id_m2reg;
  logic [RW-1:0] id_rn;
  logic          flush;
  logic          hold;
  logic [1:0]    fwda;
  logic [1:0]    fwdb;
  logic          stall;
  logic          wpcir;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_rn, flush, hold,
    input  fwda, fwdb, stall, wpcir, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_m2reg, id_rn, flush, hold,
    output fwda, fwdb, stall, wpcir, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Per-operand forwarding priority encoder: youngest available producer wins.
module fwd_sel
  import fwd_hazard_ctrl_pkg::*;
(
  input  stage_slot        ex,
  input  stage_slot        mem,
  input  logic [REG_W-1:0] src,
  output fwd_sel_t         sel
);

  // A load in EX has no data yet, so it falls through to an older MEM producer.
  always_comb begin
    sel = FWD_RF;
    if (produces(ex, src) && !ex.m2reg) begin
      sel = FWD_EXALU;
    end else if (produces(mem, src)) begin
      if (mem.m2reg) sel = FWD_MEMMO;
      else           sel = FWD_MEMALU;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline; tracks
// EX/MEM destination state and drives the ID operand-mux selects and stalls.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RW = REG_W,
  parameter int unsigned CW = 16
) (
  input logic               clk,
  input logic               clrn,
  fwd_hazard_ctrl_if.slave  bus
);

  stage_slot     ex_q, mem_q, ex_d;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] id_rs, id_rt, id_rn;
  fwd_sel_t      sel_a, sel_b;
  logic          stall;

  assign id_rs = bus.id_rs;
  assign id_rt = bus.id_rt;
  assign id_rn = bus.id_rn;

  fwd_sel u_fwda (.ex(ex_q), .mem(mem_q), .src(id_rs), .sel(sel_a));
  fwd_sel u_fwdb (.ex(ex_q), .mem(mem_q), .src(id_rt), .sel(sel_b));

  // Flush kills the ID instruction, so it can never be the victim of a load-use stall.
  assign stall = bus.id_valid & ~bus.flush & ex_q.m2reg &
                 ((bus.id_use_rs & produces(ex_q, id_rs)) |
                  (bus.id_use_rt & produces(ex_q, id_rt)));

  assign bus.fwda      = sel_a;
  assign bus.fwdb      = sel_b;
  assign bus.stall     = stall;
  assign bus.wpcir     = ~stall & ~bus.hold;
  assign bus.stall_cnt = cnt_q;

  always_comb begin
    ex_d = '0;
    if (!(stall | bus.flush | ~bus.id_valid)) begin
      ex_d.v     = 1'b1;
      ex_d.wreg  = bus.id_wreg;
      ex_d.m2reg = bus.id_m2reg;
      ex_d.rn    = id_rn;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ex_q  <= '0;
      mem_q <= '0;
      cnt_q <= '0;
    end else if (!bus.hold) begin
      mem_q <= ex_q;
      ex_q  <= ex_d;
      if (stall && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed hazard scenarios then random traffic,
// checked against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.RW(5), .CW(CW)) bus ();
  fwd_hazard_ctrl #(.RW(5), .CW(CW)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  typedef struct {
    bit v;
    bit wreg;
    bit load;
    int rd;
  } instr_t;

  instr_t pipe [2];   // [0] = instruction in EX, [1] = instruction in MEM
  int     mcnt;
  bit     known;
  int     vec;
  int     miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Where operand r should come from: newest older instruction writing r whose value exists.
  function automatic int src_of(input int r);
    if (r == 0) return 0;
    if (pipe[0].v && pipe[0].wreg && pipe[0].rd == r && !pipe[0].load) return 1;
    if (pipe[1].v && pipe[1].wreg && pipe[1].rd == r) return pipe[1].load ? 3 : 2;
    return 0;
  endfunction

  task automatic step(input bit rst, input bit v, input int rs, input int rt,
                      input bit urs, input bit urt, input bit w, input bit ld,
                      input int rn, input bit fl, input bit hd);
    bit st;
    @(negedge clk);
    clrn          = !rst;
    bus.id_valid  = v;
    bus.id_rs     = rs[4:0];
    bus.id_rt     = rt[4:0];
    bus.id_use_rs = urs;
    bus.id_use_rt = urt;
    bus.id_wreg   = w;
    bus.id_m2reg  = ld;
    bus.id_rn     = rn[4:0];
    bus.flush     = fl;
    bus.hold      = hd;
    st = v && !fl && pipe[0].v && pipe[0].wreg && pipe[0].load && pipe[0].rd != 0 &&
         ((urs && pipe[0].rd == rs) || (urt && pipe[0].rd == rt));
    #1;
    if (known) begin
      check("fwda", bus.fwda, src_of(rs));
      check("fwdb", bus.fwdb, src_of(rt));
      check("stall", bus.stall, st);
      check("wpcir", bus.wpcir, !st && !hd);
      check("stall_cnt", bus.stall_cnt, mcnt);
    end
    @(posedge clk);
    if (rst) begin
      pipe[0].v = 0;
      pipe[1].v = 0;
      mcnt      = 0;
      known     = 1;
    end else if (known && !hd) begin
      pipe[1] = pipe[0];
      if (st || fl || !v) pipe[0] = '{0, 0, 0, 0};
      else                pipe[0] = '{1, w, ld, rn};
      if (st && mcnt < CNT_MAX) mcnt++;
    end
  endtask

  task automatic issue(input bit w, input bit ld, input int rn);
    step(0, 1, 0, 0, 0, 0, w, ld, rn, 0, 0);
  endtask

  task automatic use_regs(input int rs, input int rt, input bit urs, input bit urt,
                          input bit fl, input bit hd);
    step(0, 1, rs, rt, urs, urt, 0, 0, 0, fl, hd);
  endtask

  initial begin
    vec   = 0;
    miss  = 0;
    known = 0;
    mcnt  = 0;
    pipe[0] = '{0, 0, 0, 0};
    pipe[1] = '{0, 0, 0, 0};

    // reset with random inputs, including hold and flush
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    use_regs(0, 0, 0, 0, 0, 0);

    // EX alu forward, then the same producer seen from MEM
    issue(1, 0, 3);
    use_regs(3, 0, 1, 0, 0, 0);
    use_regs(0, 3, 0, 1, 0, 0);

    // load-use: one stall cycle, then load data forwarded from MEM
    issue(1, 1, 5);
    use_regs(5, 0, 1, 0, 0, 0);
    use_regs(5, 0, 1, 0, 0, 0);

    // r0 is never forwarded; EX beats MEM for the same register
    issue(1, 0, 0);
    use_regs(0, 0, 1, 1, 0, 0);
    issue(1, 0, 7);
    issue(1, 0, 7);
    use_regs(7, 7, 1, 1, 0, 0);

    // flush beats a load-use hazard, leaving a bubble in EX
    issue(1, 1, 4);
    use_regs(4, 4, 1, 1, 1, 0);
    use_regs(4, 4, 1, 1, 0, 0);

    // hold during a stall freezes slots and the counter
    issue(1, 1, 9);
    for (int i = 0; i < 3; i++) use_regs(0, 9, 0, 1, 0, 1);
    use_regs(0, 9, 0, 1, 0, 0);
    use_regs(0, 9, 0, 1, 0, 0);

    // 20 separate load-use stalls saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      issue(1, 1, 1);
      use_regs(1, 0, 1, 0, 0, 0);
    end
    use_regs(0, 0, 0, 0, 0, 0);

    // random traffic on a small register window to provoke hits
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 7)),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipelined CPU.
- Keeps its own shadow copies of the EX- and MEM-stage destination-register state.
- Drives the 2-bit selects of the two ID-stage operand mux4x32 instances (fwda, fwdb).
- Detects load-use hazards: stalls the PC and IF/ID registers and inserts a bubble into EX.

Parameters:
- RW, 5, register-address width (matches the mux2x5 destination select).
- CW, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge.
- clrn  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RW  ID source register A.
- id_rt  in  RW  ID source register B.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wreg  in  1  instruction writes the register file.
- id_m2reg  in  1  instruction is a load (result comes from memory).
- id_rn  in  RW  destination register, post rt/rd select.
- flush  in  1  kill the ID instruction (taken branch/jump).
- hold  in  1  global freeze (memory wait); all state holds.
- fwda  out  2  operand A select: 00 regfile, 01 EX alu, 10 MEM alu, 11 MEM load data.
- fwdb  out  2  operand B select, same encoding.
- stall  out  1  load-use stall this cycle.
- wpcir  out  1  PC and IF/ID write enable, equal to ~stall & ~hold.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- State registers: EX slot {v, wreg, m2reg, rn} and MEM slot {v, wreg, m2reg, rn}, plus stall_cnt.
- Reset (clrn=0 at a rising edge): both slot valid bits are cleared and stall_cnt is set to 0.
  - Outputs after reset: fwda=fwdb=00, stall=0, wpcir=1 (given hold=0).
  - Reset overrides hold and flush.
- fwda, fwdb, stall and wpcir are combinational from the ID inputs and the slot registers; zero added latency.
- fwda priority, first match wins:
  - EX match: EX.v & EX.wreg & EX.rn!=0 & EX.rn==id_rs & ~EX.m2reg -> 01.
  - Else MEM match: MEM.v & MEM.wreg & MEM.rn!=0 & MEM.rn==id_rs -> 11 if MEM.m2reg, else 10.
  - Else 00.
- fwdb: same rules using id_rt.
- The gating inputs id_use_rs/id_use_rt do not alter fwda/fwdb; they affect only stall.
- stall condition: id_valid & ~flush & EX.v & EX.wreg & EX.m2reg & EX.rn!=0 and either:
  - id_use_rs & EX.rn==id_rs, or
  - id_use_rt & EX.rn==id_rt.
- Register 0 is never a forwarding or stall source.
- WB-stage hazards are not handled here; the regfile writes before read.
- Clock edge, clrn=1, hold=1: all registers hold, stall_cnt unchanged.
- Clock edge, clrn=1, hold=0:
  - MEM slot <= EX slot.
  - EX slot <= bubble (v=0) if stall | flush | ~id_valid.
  - Otherwise EX slot <= {1, id_wreg, id_m2reg, id_rn}.
  - stall_cnt increments when stall=1; it saturates at all-ones.
- Simultaneous flush and stall hazard: flush wins, so stall=0 and a bubble is inserted.
- A load-use stall lasts exactly one cycle: after the bubble, the load sits in MEM and is forwarded with select 11.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMMO=2'b11.
  - A stage_slot struct {v, wreg, m2reg, rn}.
- Natural sub-module: fwd_sel. It is a combinational per-operand priority encoder, instantiated once for rs and once for rt.

Test Plan:
- Reset: clrn=0 for 2 cycles with random inputs -> fwda=fwdb=00, stall=0, stall_cnt=0.
- EX alu forward: issue "add r3" (wreg=1, m2reg=0, rn=3), then ID rs=3 -> fwda=01.
  - One cycle later with ID rt=3 -> fwdb=10.
- Load-use: issue "lw r5", then ID use_rs=1, rs=5 -> stall=1, wpcir=0, EX bubble.
  - Next cycle with the same ID -> stall=0, fwda=11, stall_cnt=1.
- r0 and priority cases:
  - Write to r0, then ID rs=0 -> fwda=00.
  - EX and MEM both write r7, then ID rs=7 -> fwda=01 (EX wins).
- Flush vs stall: load r4 in EX, ID uses r4, flush=1 -> stall=0, wpcir=1.
  - Next cycle EX.v=0.
- Hold and saturation: hold=1 for 3 cycles during a stall -> slots and stall_cnt frozen.
  - With CW=4, force 20 stall cycles -> stall_cnt=15.
